// File: rtl/mem_access_stage.sv
// Data-memory access stage feeding the EX/WB register. Non-memory ops pass
// straight through; LW/SW run a req/ack transaction and stall upstream.
//
// Ports:
//   clk, rstd       clock, synchronous active-high reset
//   op_in           opcode from execute stage
//   alu_result_in   effective byte address for LW/SW
//   ot_in           store data for SW
//   stall           hold PC, IF/ID and ID/EX this cycle
//   op_out          opcode to EX/WB (NOP bubble while stalled)
//   dm_data_out     load data to EX/WB
//   fault_out       one-cycle pulse on misaligned access or timeout
//   dm_req/we/addr/wdata  registered data-memory request
//   dm_ack, dm_rdata      memory completion and read data
module mem_access_stage #(
    parameter logic [5:0]  OP_LW   = 6'd35,
    parameter logic [5:0]  OP_SW   = 6'd43,
    parameter logic [5:0]  OP_NOP  = 6'd55,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rstd,
    input  logic [5:0]  op_in,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] ot_in,
    output logic        stall,
    output logic [5:0]  op_out,
    output logic [31:0] dm_data_out,
    output logic        fault_out,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    // Timeout fires on the WAIT cycle where cnt reaches TIMEOUT-1.
    localparam bit          TO_EN    = (TIMEOUT != 0);
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    state_t      state;
    logic [15:0] cnt;
    logic [31:0] data_q;
    logic [5:0]  op_q;
    logic        flt_q;

    logic is_mem;
    logic misal;

    assign is_mem = (op_in == OP_LW) || (op_in == OP_SW);
    assign misal  = |alu_result_in[1:0];

    always_ff @(posedge clk) begin
        if (rstd) begin
            state    <= S_IDLE;
            cnt      <= 16'd0;
            data_q   <= 32'd0;
            op_q     <= OP_NOP;
            flt_q    <= 1'b0;
            dm_req   <= 1'b0;
            dm_we    <= 1'b0;
            dm_addr  <= 32'd0;
            dm_wdata <= 32'd0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (is_mem && misal) begin
                        op_q   <= OP_NOP;
                        flt_q  <= 1'b1;
                        data_q <= 32'd0;
                        state  <= S_DONE;
                    end else if (is_mem) begin
                        dm_req   <= 1'b1;
                        dm_we    <= (op_in == OP_SW);
                        dm_addr  <= alu_result_in;
                        dm_wdata <= ot_in;
                        op_q     <= op_in;
                        cnt      <= 16'd0;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Ack has priority over a timeout in the same cycle.
                    if (dm_ack) begin
                        dm_req <= 1'b0;
                        data_q <= (op_q == OP_LW) ? dm_rdata : 32'd0;
                        state  <= S_DONE;
                    end else if (TO_EN && (cnt == CNT_LAST)) begin
                        dm_req <= 1'b0;
                        op_q   <= OP_NOP;
                        flt_q  <= 1'b1;
                        data_q <= 32'hDEADBEEF;
                        state  <= S_DONE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_DONE: begin
                    flt_q <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        stall       = 1'b0;
        op_out      = op_in;
        dm_data_out = 32'd0;
        fault_out   = 1'b0;
        unique case (1'b1)
            (state == S_IDLE): begin
                if (is_mem) begin
                    stall  = 1'b1;
                    op_out = OP_NOP;
                end
            end
            (state == S_WAIT): begin
                stall  = 1'b1;
                op_out = OP_NOP;
            end
            (state == S_DONE): begin
                // op_in is the same stalled instruction; ignore it here.
                op_out      = op_q;
                dm_data_out = data_q;
                fault_out   = flt_q;
            end
            default: begin
                stall  = 1'b0;
                op_out = op_in;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Testbench for mem_access_stage: transaction-level model with a per-cycle
// expectation queue, directed scenarios and randomized instruction streams.
module tb_mem_access_stage;

    localparam logic [5:0] LW  = 6'd35;
    localparam logic [5:0] SW  = 6'd43;
    localparam logic [5:0] NOP = 6'd55;
    localparam int         TO  = 4;

    logic        clk = 1'b0;
    logic        rstd;
    logic [5:0]  op_in;
    logic [31:0] alu_result_in;
    logic [31:0] ot_in;
    logic        stall;
    logic [5:0]  op_out;
    logic [31:0] dm_data_out;
    logic        fault_out;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;

    mem_access_stage #(
        .OP_LW(LW), .OP_SW(SW), .OP_NOP(NOP), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rstd(rstd),
        .op_in(op_in), .alu_result_in(alu_result_in), .ot_in(ot_in),
        .stall(stall), .op_out(op_out), .dm_data_out(dm_data_out),
        .fault_out(fault_out), .dm_req(dm_req), .dm_we(dm_we),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic [5:0]  op;
        logic [31:0] data;
        logic        flt;
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad   = 0;

    // Observed summary of the most recent stall run, latched on stall=0.
    int          run_len = 0, req_len = 0;
    int          last_run, last_req;
    logic [5:0]  last_op;
    logic [31:0] last_data;
    logic        last_flt;

    function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", n, a, e, $time);
        end
    endfunction

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("stall", 32'(stall), 32'(e.stall));
            chk("op_out", 32'(op_out), 32'(e.op));
            chk("dm_data_out", dm_data_out, e.data);
            chk("fault_out", 32'(fault_out), 32'(e.flt));
            chk("dm_req", 32'(dm_req), 32'(e.req));
            if (e.req) begin
                chk("dm_we", 32'(dm_we), 32'(e.we));
                chk("dm_addr", dm_addr, e.addr);
                chk("dm_wdata", dm_wdata, e.wdata);
            end
        end
        if (stall) begin
            run_len++;
            if (dm_req) req_len++;
        end else begin
            last_run  = run_len;
            last_req  = req_len;
            last_op   = op_out;
            last_data = dm_data_out;
            last_flt  = fault_out;
            run_len   = 0;
            req_len   = 0;
        end
    end

    task automatic cyc(input exp_t e);
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t mk(logic s, logic [5:0] o, logic [31:0] d,
                                logic f, logic r, logic w,
                                logic [31:0] a, logic [31:0] wd);
        exp_t e;
        e.stall = s; e.op = o; e.data = d; e.flt = f;
        e.req = r; e.we = w; e.addr = a; e.wdata = wd;
        return e;
    endfunction

    // k: WAIT cycle (1-based) in which ack arrives, 0 = never.
    // rs: WAIT cycle in which reset is asserted, 0 = never.
    task automatic run(input logic [5:0] op, input logic [31:0] a,
                       input logic [31:0] d, input int k,
                       input logic [31:0] rd, input int rs);
        bit mem;
        bit we;
        int ack_at;
        mem = (op == LW) || (op == SW);
        we  = (op == SW);
        op_in = op; alu_result_in = a; ot_in = d;
        dm_ack = 1'($urandom); dm_rdata = $urandom;
        if (!mem) begin
            cyc(mk(0, op, 0, 0, 0, 0, 0, 0));
            return;
        end
        if (a[1:0] != 2'b00) begin
            cyc(mk(1, NOP, 0, 0, 0, 0, 0, 0));
            dm_ack = 1'($urandom);
            cyc(mk(0, NOP, 0, 1, 0, 0, 0, 0));
            return;
        end
        cyc(mk(1, NOP, 0, 0, 0, 0, 0, 0));
        ack_at = (k >= 1 && k <= TO) ? k : 0;
        for (int j = 1; j <= TO; j++) begin
            dm_ack   = (j == ack_at);
            dm_rdata = (j == ack_at) ? rd : $urandom;
            rstd     = (j == rs);
            cyc(mk(1, NOP, 0, 0, 1, we, a, d));
            if (j == rs) begin
                rstd = 1'b0;
                return;
            end
            if (j == ack_at) break;
        end
        dm_ack = 1'($urandom); dm_rdata = $urandom;
        if (ack_at != 0)
            cyc(mk(0, op, (op == LW) ? rd : 32'd0, 0, 0, 0, 0, 0));
        else
            cyc(mk(0, NOP, 32'hDEADBEEF, 1, 0, 0, 0, 0));
    endtask

    function automatic logic [5:0] rand_nonmem();
        logic [5:0] o;
        do o = 6'($urandom); while (o == LW || o == SW);
        return o;
    endfunction

    initial begin
        rstd = 1'b1; op_in = 6'd0; alu_result_in = 0; ot_in = 0;
        dm_ack = 1'b0; dm_rdata = 0;
        repeat (2) @(posedge clk);
        #1 rstd = 1'b0;

        chk("rst_req", 32'(dm_req), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_op", 32'(op_out), 32'd0);
        chk("rst_flt", 32'(fault_out), 32'd0);

        repeat (5) run(6'd0, $urandom, $urandom, 0, 0, 0);
        chk("rtype_run", last_run, 0);

        run(LW, 32'h100, $urandom, 3, 32'h12345678, 0);
        chk("lw_stall", last_run, 4);
        chk("lw_req", last_req, 3);
        chk("lw_op", 32'(last_op), 32'd35);
        chk("lw_data", last_data, 32'h12345678);
        chk("lw_we", 32'(dm_we), 32'd0);
        chk("lw_addr", dm_addr, 32'h100);

        run(SW, 32'h204, 32'hCAFEF00D, 1, $urandom, 0);
        chk("sw_stall", last_run, 2);
        chk("sw_op", 32'(last_op), 32'd43);
        chk("sw_data", last_data, 32'd0);
        chk("sw_we", 32'(dm_we), 32'd1);
        chk("sw_wdata", dm_wdata, 32'hCAFEF00D);

        run(LW, 32'h102, $urandom, 1, $urandom, 0);
        chk("mis_stall", last_run, 1);
        chk("mis_req", last_req, 0);
        chk("mis_op", 32'(last_op), 32'd55);
        chk("mis_flt", 32'(last_flt), 32'd1);

        run(LW, 32'h300, $urandom, 0, 0, 0);
        chk("to_req", last_req, 4);
        chk("to_op", 32'(last_op), 32'd55);
        chk("to_data", last_data, 32'hDEADBEEF);
        chk("to_flt", 32'(last_flt), 32'd1);

        run(LW, 32'h300, $urandom, 4, 32'hA5A5_0001, 0);
        chk("ack4_req", last_req, 4);
        chk("ack4_op", 32'(last_op), 32'd35);
        chk("ack4_flt", 32'(last_flt), 32'd0);

        run(LW, 32'h400, $urandom, 0, 0, 2);
        run(6'd0, 0, 0, 0, 0, 0);
        chk("rstw_run", last_run, 3);
        chk("rstw_req", last_req, 2);
        chk("rstw_op", 32'(last_op), 32'd0);

        for (int i = 0; i < 300; i++) begin
            int          r;
            logic [5:0]  op;
            logic [31:0] a;
            r = int'($urandom_range(0, 9));
            if (r < 4) op = rand_nonmem();
            else op = (r < 7) ? LW : SW;
            a = $urandom;
            if ($urandom_range(0, 4) != 0) a[1:0] = 2'b00;
            run(op, a, $urandom,
                int'($urandom_range(0, TO + 1)), $urandom, 0);
        end

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
